// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op and state encodings
// plus the iteration counter width helper.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

  localparam int MD_WIDTH_DEF = 32;

  function automatic int md_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration: shift-add for multiply (mode=0) or restoring
// subtract for divide (mode=1) on the {acc,q} pair.
module md_iter_step
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEF
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Single step datapath; diff_s[WIDTH] is the borrow of the trial subtract.
  always_comb begin
    sum_s     = {1'b0, acc} + (q[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    shifted_s = {acc, q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, operand};
    acc_nxt   = acc;
    q_nxt     = q;
    if (mode) begin
      if (!diff_s[WIDTH]) begin
        acc_nxt = diff_s[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted_s[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum_s[WIDTH:1];
      q_nxt   = {sum_s[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/md_seq_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional single-cycle multiply: define MD_FAST_MULT_EN.
module md_seq_ctrl
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = md_cnt_w(WIDTH);

  md_state_e        state_r, state_nxt_s;
  md_op_e           op_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] acc_r, q_r, opnd_r, a_orig_r, hi_r, lo_r;
  logic             neg_q_r, neg_r_r, bzero_r, done_r;
  logic [WIDTH-1:0] acc_nxt_s, q_nxt_s;
  logic             a_neg_s, b_neg_s, fast_s;
  logic [WIDTH-1:0] a_abs_s, b_abs_s, quo_s, rem_s;
  logic [2*WIDTH-1:0] prod_s, mul_init_s;

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .mode    (op_r[1]),
    .acc     (acc_r),
    .q       (q_r),
    .operand (opnd_r),
    .acc_nxt (acc_nxt_s),
    .q_nxt   (q_nxt_s)
  );

  // Operand magnitudes and the initial {acc,q} for a multiply.
  always_comb begin
    a_neg_s = md_op[0] & A[WIDTH-1];
    b_neg_s = md_op[0] & B[WIDTH-1];
    a_abs_s = a_neg_s ? -A : A;
    b_abs_s = b_neg_s ? -B : B;
`ifdef MD_FAST_MULT_EN
    fast_s     = ~md_op[1];
    mul_init_s = a_abs_s * b_abs_s;
`else
    fast_s     = 1'b0;
    mul_init_s = {{WIDTH{1'b0}}, b_abs_s};
`endif
  end

  // Sign correction of the finished magnitudes; divide by zero bypasses it.
  always_comb begin
    if (neg_q_r) prod_s = -{acc_r, q_r};
    else         prod_s = {acc_r, q_r};
    if (bzero_r) begin
      quo_s = {WIDTH{1'b1}};
      rem_s = a_orig_r;
    end else begin
      quo_s = neg_q_r ? -q_r : q_r;
      rem_s = neg_r_r ? -acc_r : acc_r;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = fast_s ? S_FIX : S_CALC;
        else       state_nxt_s = S_IDLE;
      end
      S_CALC: begin
        if (cnt_r == CNT_W'(WIDTH-1)) state_nxt_s = S_FIX;
        else                          state_nxt_s = S_CALC;
      end
      S_FIX:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Datapath registers, HI/LO and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r     <= MD_MULTU;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      q_r      <= {WIDTH{1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      a_orig_r <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      bzero_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (start) begin
            op_r     <= md_op_e'(md_op);
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            bzero_r  <= (B == {WIDTH{1'b0}});
            a_orig_r <= A;
            if (md_op[1]) begin
              acc_r  <= {WIDTH{1'b0}};
              q_r    <= a_abs_s;
              opnd_r <= b_abs_s;
            end else begin
              {acc_r, q_r} <= mul_init_s;
              opnd_r       <= a_abs_s;
            end
          end else begin
            if (mthi) hi_r <= A;
            if (mtlo) lo_r <= A;
          end
        end
        S_CALC: begin
          acc_r <= acc_nxt_s;
          q_r   <= q_nxt_s;
          cnt_r <= cnt_r + CNT_W'(1);
        end
        S_FIX: begin
          done_r <= 1'b1;
          if (op_r[1]) begin
            hi_r <= rem_s;
            lo_r <= quo_s;
          end else begin
            hi_r <= prod_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_s[WIDTH-1:0];
          end
        end
        default: done_r <= 1'b0;
      endcase
    end
  end

  assign busy = (state_r != S_IDLE);
  assign done = done_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed, table-driven bench for md_seq_ctrl (default iterative build).
module tb_md_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  md_op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] HI, LO;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] model_hi, model_lo;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs[12];

  md_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(A), .B(B), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_n, done_n, done_at;
    busy_n = 0; done_n = 0; done_at = 0;
    @(negedge clk); md_op = op; A = a; B = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; A = 32'h0; B = 32'h0;
    for (int c = 1; c <= 36; c++) begin
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = c; end
      if (c == 16) begin
        check({tag, "_hold_hi"}, HI, model_hi);
        check({tag, "_hold_lo"}, LO, model_lo);
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, busy_n, 32'd33);
    check({tag, "_done_pulses"}, done_n, 32'd1);
    check({tag, "_done_cycle"}, done_at, 32'd34);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    int busy_n, done_n;
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{2'b10, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[5]  = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[9]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[10] = '{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[11] = '{2'b01, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};

    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    md_op = 2'b00; A = 32'h0; B = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    model_hi = 32'h0; model_lo = 32'h0;

    // MT moves in IDLE
    A = 32'h00001234; mtlo = 1'b1;
    @(negedge clk); mtlo = 1'b0;
    check("mtlo_lo", LO, 32'h00001234);
    check("mtlo_hi", HI, 32'h00000000);
    A = 32'hABCD0000; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    check("mtboth_hi", HI, 32'hABCD0000);
    check("mtboth_lo", LO, 32'hABCD0000);
    model_hi = 32'hABCD0000; model_lo = 32'hABCD0000;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // start together with mthi, then start/mthi/mtlo while busy: all moves ignored
    @(negedge clk); md_op = 2'b10; A = 32'd100; B = 32'd7; start = 1'b1; mthi = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; mthi = 1'b0;
    check("startwins_hi", HI, model_hi);
    busy_n = 0; done_n = 0;
    for (int c = 1; c <= 36; c++) begin
      if (busy) busy_n++;
      if (done) done_n++;
      if (c == 5) begin
        md_op = 2'b00; A = 32'hDEADBEEF; B = 32'h3; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      if (c == 6) begin
        check("busyign_hi", HI, model_hi);
        check("busyign_lo", LO, model_lo);
      end
      @(negedge clk);
    end
    check("busyign_busy_cycles", busy_n, 32'd33);
    check("busyign_done_pulses", done_n, 32'd1);
    check("busyign_res_hi", HI, 32'h00000002);
    check("busyign_res_lo", LO, 32'h0000000E);
    check("busyign_idle", {31'd0, busy}, 32'd0);

    // reset in the middle of a DIV
    @(negedge clk); md_op = 2'b11; A = 32'hFFFFFFF9; B = 32'h2; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", HI, 32'h0);
    check("midrst_lo", LO, 32'h0);
    busy_n = 0; done_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_n++;
      if (done) done_n++;
      @(negedge clk);
    end
    check("midrst_no_done", done_n, 32'd0);
    check("midrst_no_busy", busy_n, 32'd0);
    model_hi = 32'h0; model_lo = 32'h0;
    run_op("post_rst_multu", 2'b00, 32'd3, 32'd4, 32'h0, 32'h0000000C);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
